// File: rtl/unified_mem_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and MEM-stage data access.
// Data accesses win by default; a saturating run counter forces a fetch grant so fetch is never starved.
module unified_mem_arbiter #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MAX_D_RUN = 4
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ready,
    output logic          if_stall,
    input  logic          d_read,
    input  logic          d_write,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_ready,
    output logic          d_stall,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack
);

    localparam int RW = (MAX_D_RUN < 1) ? 1 : $clog2(MAX_D_RUN + 1);
    localparam logic [RW-1:0] RUN_MAX = RW'(MAX_D_RUN);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_IF_BUSY = 2'd1,
        S_D_BUSY  = 2'd2
    } state_t;

    state_t          r_state;
    logic [RW-1:0]   r_run;
    logic            r_mem_req;
    logic            r_mem_we;
    logic [AW-1:0]   r_mem_addr;
    logic [DW-1:0]   r_mem_wdata;
    logic [DW-1:0]   r_if_rdata;
    logic [DW-1:0]   r_d_rdata;
    logic            r_if_ready;
    logic            r_d_ready;

    logic            w_d_req;
    logic            w_d_win;
    logic [RW-1:0]   w_run_inc;

    assign w_d_req   = d_read | d_write;
    // Data keeps priority until it has won MAX_D_RUN grants in a row over a waiting fetch.
    assign w_d_win   = w_d_req & ((r_run < RUN_MAX) | ~if_req);
    assign w_run_inc = (r_run == RUN_MAX) ? r_run : r_run + RW'(1);

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign if_rdata  = r_if_rdata;
    assign d_rdata   = r_d_rdata;
    assign if_ready  = r_if_ready;
    assign d_ready   = r_d_ready;
    assign if_stall  = if_req & ~r_if_ready;
    assign d_stall   = w_d_req & ~r_d_ready;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state     <= S_IDLE;
            r_run       <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_rdata  <= '0;
            r_d_rdata   <= '0;
            r_if_ready  <= 1'b0;
            r_d_ready   <= 1'b0;
        end else begin
            r_if_ready <= 1'b0;
            r_d_ready  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_d_win) begin
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= d_write;
                        r_mem_addr  <= d_addr;
                        r_mem_wdata <= d_wdata;
                        r_run       <= if_req ? w_run_inc : '0;
                        r_state     <= S_D_BUSY;
                    end else if (if_req) begin
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b0;
                        r_mem_addr  <= if_addr;
                        r_run       <= '0;
                        r_state     <= S_IF_BUSY;
                    end
                end
                S_IF_BUSY: begin
                    if (mem_ack) begin
                        r_if_rdata <= mem_rdata;
                        r_if_ready <= 1'b1;
                        r_mem_req  <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
                S_D_BUSY: begin
                    // Stores complete without touching the last load value.
                    if (mem_ack) begin
                        if (!r_mem_we) begin
                            r_d_rdata <= mem_rdata;
                        end
                        r_d_ready <= 1'b1;
                        r_mem_req <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench for unified_mem_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level model of the grant rules and a behavioural memory.
module tb_unified_mem_arbiter;

    localparam int MAX = 4;

    logic        CLK, RST;
    logic        if_req, d_read, d_write;
    logic [31:0] if_addr, d_addr, d_wdata;
    logic [31:0] if_rdata, d_rdata;
    logic        if_ready, if_stall, d_ready, d_stall;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int n_cmp = 0;
    int n_fail = 0;

    bit ack_tied = 0;
    bit ack_rand = 0;
    int ack_lat = 0;
    int rsp_cnt, rsp_lat;
    bit rsp_done;

    logic [31:0] mem [bit [31:0]];
    logic [31:0] exp_if_rdata, exp_d_rdata;

    unified_mem_arbiter #(.AW(32), .DW(32), .MAX_D_RUN(MAX)) dut (
        .CLK(CLK), .RST(RST),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready), .if_stall(if_stall),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready), .d_stall(d_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return {~a[15:0], a[15:0]} ^ 32'h5A5A_0000;
    endfunction

    // Memory responder: acks once per request after a chosen latency, junk rdata otherwise.
    initial begin
        mem_ack = 1'b0; mem_rdata = '0; rsp_cnt = 0; rsp_lat = 0; rsp_done = 0;
        forever begin
            @(posedge CLK); #2;
            mem_rdata = $urandom;
            if (!RST || !mem_req) begin
                rsp_cnt = 0; rsp_done = 0; mem_ack = ack_tied;
            end else if (rsp_done) begin
                mem_ack = ack_tied;
            end else begin
                if (rsp_cnt == 0) rsp_lat = ack_rand ? int'($urandom_range(0, 3)) : ack_lat;
                if (rsp_cnt >= rsp_lat) begin
                    mem_ack = 1'b1; rsp_done = 1;
                    if (mem_we) mem[mem_addr] = mem_wdata;
                    else mem_rdata = rd(mem_addr);
                end else begin
                    mem_ack = 1'b0; rsp_cnt++;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK); #1;
    endtask

    task automatic test_reset();
        repeat (3) tick();
        n_cmp++; if ({mem_req, mem_we, if_ready, d_ready, if_stall, d_stall} !== 6'b0) begin
            n_fail++; $display("FAIL reset_ctrl got=%b want=000000", {mem_req, mem_we, if_ready, d_ready, if_stall, d_stall}); end
        n_cmp++; if ({mem_addr, mem_wdata} !== 64'h0) begin
            n_fail++; $display("FAIL reset_mem got=%h want=0", {mem_addr, mem_wdata}); end
        n_cmp++; if ({if_rdata, d_rdata} !== 64'h0) begin
            n_fail++; $display("FAIL reset_rdata got=%h want=0", {if_rdata, d_rdata}); end
        RST = 1'b1;
        tick(); tick();
        n_cmp++; if (mem_req !== 1'b0) begin
            n_fail++; $display("FAIL reset_idle got=%b want=0", mem_req); end
        exp_if_rdata = '0; exp_d_rdata = '0;
    endtask

    task automatic test_fetch_only();
        mem[32'h10] = 32'h00A00093;
        ack_lat = 2;
        if_req = 1'b1; if_addr = 32'h10;
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (c < 4) begin
                n_cmp++; if ({mem_req, mem_we, if_ready, if_stall, mem_addr} !== {4'b1001, 32'h10}) begin
                    n_fail++; $display("FAIL fetch_hold c%0d got=%h want=%h", c, {mem_req, mem_we, if_ready, if_stall, mem_addr}, {4'b1001, 32'h10}); end
            end else begin
                n_cmp++; if ({if_ready, mem_req, if_stall} !== 3'b100) begin
                    n_fail++; $display("FAIL fetch_ready c4 got=%b want=100", {if_ready, mem_req, if_stall}); end
                n_cmp++; if (if_rdata !== 32'h00A00093) begin
                    n_fail++; $display("FAIL fetch_rdata got=%h want=00a00093", if_rdata); end
            end
        end
        if_req = 1'b0;
        exp_if_rdata = 32'h00A00093;
        tick();
        n_cmp++; if ({if_ready, mem_req} !== 2'b00) begin
            n_fail++; $display("FAIL fetch_single_pulse got=%b want=00", {if_ready, mem_req}); end
    endtask

    task automatic test_simultaneous();
        bit got;
        int stall_bad;
        ack_lat = 1;
        if_req = 1'b1; if_addr = 32'h20; d_read = 1'b1; d_addr = 32'h100;
        tick();
        n_cmp++; if ({mem_req, mem_we, mem_addr} !== {2'b10, 32'h100}) begin
            n_fail++; $display("FAIL sim_grant_data got=%h want=%h", {mem_req, mem_we, mem_addr}, {2'b10, 32'h100}); end
        got = 0; stall_bad = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (!if_stall || if_ready) stall_bad++;
            tick();
            if (d_ready) got = 1;
        end
        if (!if_stall || if_ready) stall_bad++;
        n_cmp++; if (got !== 1'b1) begin
            n_fail++; $display("FAIL sim_d_ready got=%b want=1", got); end
        n_cmp++; if (stall_bad !== 0) begin
            n_fail++; $display("FAIL sim_if_stall bad_cycles got=%0d want=0", stall_bad); end
        exp_d_rdata = rd(32'h100);
        n_cmp++; if (d_rdata !== exp_d_rdata) begin
            n_fail++; $display("FAIL sim_d_rdata got=%h want=%h", d_rdata, exp_d_rdata); end
        d_read = 1'b0;
        tick();
        n_cmp++; if ({mem_req, mem_we, d_ready, mem_addr} !== {3'b100, 32'h20}) begin
            n_fail++; $display("FAIL sim_grant_fetch got=%h want=%h", {mem_req, mem_we, d_ready, mem_addr}, {3'b100, 32'h20}); end
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            if (if_ready) got = 1;
        end
        exp_if_rdata = rd(32'h20);
        n_cmp++; if ({got, if_rdata} !== {1'b1, exp_if_rdata}) begin
            n_fail++; $display("FAIL sim_fetch_done got=%h want=%h", {got, if_rdata}, {1'b1, exp_if_rdata}); end
        if_req = 1'b0;
        tick();
    endtask

    task automatic test_store();
        bit got;
        ack_lat = 3;
        d_write = 1'b1; d_addr = 32'h200; d_wdata = 32'hDEADBEEF;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            if (d_ready) got = 1;
            else begin
                n_cmp++; if ({mem_req, mem_we, mem_addr, mem_wdata} !== {2'b11, 32'h200, 32'hDEADBEEF}) begin
                    n_fail++; $display("FAIL store_hold got=%h want=%h", {mem_req, mem_we, mem_addr, mem_wdata}, {2'b11, 32'h200, 32'hDEADBEEF}); end
            end
        end
        n_cmp++; if (got !== 1'b1) begin
            n_fail++; $display("FAIL store_ready got=%b want=1", got); end
        n_cmp++; if (d_rdata !== exp_d_rdata) begin
            n_fail++; $display("FAIL store_rdata_kept got=%h want=%h", d_rdata, exp_d_rdata); end
        n_cmp++; if (rd(32'h200) !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL store_mem got=%h want=deadbeef", rd(32'h200)); end
        d_write = 1'b0;
        tick();
        n_cmp++; if (d_ready !== 1'b0) begin
            n_fail++; $display("FAIL store_single_pulse got=%b want=0", d_ready); end
    endtask

    task automatic test_starvation();
        int g, nd;
        bit prev_req, is_f, got;
        ack_lat = 1;
        if_req = 1'b1; if_addr = 32'h40; d_read = 1'b1; d_addr = 32'h300;
        g = 0; nd = 0; prev_req = 0;
        for (int c = 0; c < 300 && g < 10; c++) begin
            tick();
            if (d_ready) begin
                exp_d_rdata = rd(d_addr);
                n_cmp++; if (d_rdata !== exp_d_rdata) begin
                    n_fail++; $display("FAIL starve_d_rdata got=%h want=%h", d_rdata, exp_d_rdata); end
                nd++; d_addr = 32'h300 + 32'(nd * 4);
            end
            if (mem_req && !prev_req) begin
                is_f = (mem_addr == 32'h40);
                n_cmp++; if (is_f !== (g % 5 == 4)) begin
                    n_fail++; $display("FAIL starve_grant%0d fetch got=%b want=%b", g, is_f, (g % 5 == 4)); end
                g++;
            end
            prev_req = mem_req;
        end
        n_cmp++; if (g !== 10) begin
            n_fail++; $display("FAIL starve_count got=%0d want=10", g); end
        d_read = 1'b0;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            if (if_ready) got = 1;
        end
        exp_if_rdata = rd(32'h40);
        n_cmp++; if ({got, if_rdata} !== {1'b1, exp_if_rdata}) begin
            n_fail++; $display("FAIL starve_fetch_done got=%h want=%h", {got, if_rdata}, {1'b1, exp_if_rdata}); end
        if_req = 1'b0;
        tick();
    endtask

    task automatic test_zero_wait();
        bit e_r;
        ack_tied = 1; ack_lat = 0;
        d_read = 1'b1; d_addr = 32'h104;
        tick();
        n_cmp++; if ({mem_req, d_ready} !== 2'b10) begin
            n_fail++; $display("FAIL zw_grant got=%b want=10", {mem_req, d_ready}); end
        tick();
        exp_d_rdata = rd(32'h104);
        n_cmp++; if ({mem_req, d_ready, d_rdata} !== {2'b01, exp_d_rdata}) begin
            n_fail++; $display("FAIL zw_ready got=%h want=%h", {mem_req, d_ready, d_rdata}, {2'b01, exp_d_rdata}); end
        d_read = 1'b0;
        if_req = 1'b1; if_addr = 32'h60;
        for (int c = 1; c <= 8; c++) begin
            tick();
            e_r = (c % 2 == 0);
            n_cmp++; if ({if_ready, mem_req, d_ready} !== {e_r, ~e_r, 1'b0}) begin
                n_fail++; $display("FAIL zw_stream c%0d got=%b want=%b", c, {if_ready, mem_req, d_ready}, {e_r, ~e_r, 1'b0}); end
            if (c == 8) if_req = 1'b0;
        end
        tick();
        exp_if_rdata = rd(32'h60);
        n_cmp++; if ({if_ready, mem_req, if_rdata} !== {2'b00, exp_if_rdata}) begin
            n_fail++; $display("FAIL zw_end got=%h want=%h", {if_ready, mem_req, if_rdata}, {2'b00, exp_if_rdata}); end
        ack_tied = 0;
        tick();
    endtask

    task automatic test_reset_mid();
        bit got, d_seen;
        ack_lat = 5;
        d_read = 1'b1; d_addr = 32'h108;
        tick(); tick();
        n_cmp++; if ({mem_req, d_stall} !== 2'b11) begin
            n_fail++; $display("FAIL rstmid_busy got=%b want=11", {mem_req, d_stall}); end
        #2; RST = 1'b0; #1;
        n_cmp++; if ({mem_req, d_ready, if_ready} !== 3'b000) begin
            n_fail++; $display("FAIL rstmid_abort got=%b want=000", {mem_req, d_ready, if_ready}); end
        n_cmp++; if ({d_rdata, if_rdata} !== 64'h0) begin
            n_fail++; $display("FAIL rstmid_rdata got=%h want=0", {d_rdata, if_rdata}); end
        exp_d_rdata = '0; exp_if_rdata = '0;
        d_read = 1'b0; if_req = 1'b1; if_addr = 32'h50;
        tick(); tick();
        n_cmp++; if (mem_req !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_held got=%b want=0", mem_req); end
        RST = 1'b1;
        tick();
        n_cmp++; if ({mem_req, mem_we, mem_addr} !== {2'b10, 32'h50}) begin
            n_fail++; $display("FAIL rstmid_fetch_first got=%h want=%h", {mem_req, mem_we, mem_addr}, {2'b10, 32'h50}); end
        got = 0; d_seen = 0;
        for (int i = 0; i < 30 && !got; i++) begin
            tick();
            if (d_ready) d_seen = 1;
            if (if_ready) got = 1;
        end
        exp_if_rdata = rd(32'h50);
        n_cmp++; if ({got, d_seen, if_rdata} !== {2'b10, exp_if_rdata}) begin
            n_fail++; $display("FAIL rstmid_after got=%h want=%h", {got, d_seen, if_rdata}, {2'b10, exp_if_rdata}); end
        if_req = 1'b0;
        tick();
    endtask

    // Transaction-level model: who may be granted, in which order, and what each completion returns.
    task automatic test_random(input int ncyc);
        bit m_busy, m_own_d, p_if, p_d, exp_d, if_done, d_done, start, w;
        int m_run;
        logic [31:0] e_addr;
        m_busy = 0; m_own_d = 0; m_run = 0;
        ack_rand = 1; ack_tied = 0;
        p_if = if_req; p_d = d_read | d_write;
        for (int c = 0; c < ncyc; c++) begin
            tick();
            if_done = 0; d_done = 0;
            n_cmp++; if ({if_stall, d_stall} !== {if_req & ~if_ready, (d_read | d_write) & ~d_ready}) begin
                n_fail++; $display("FAIL rnd_stall c%0d got=%b want=%b", c, {if_stall, d_stall}, {if_req & ~if_ready, (d_read | d_write) & ~d_ready}); end
            if (!m_busy) begin
                if (p_if || p_d) begin
                    exp_d = p_d && (m_run < MAX || !p_if);
                    e_addr = exp_d ? d_addr : if_addr;
                    n_cmp++; if ({mem_req, mem_we, mem_addr} !== {1'b1, exp_d & d_write, e_addr}) begin
                        n_fail++; $display("FAIL rnd_grant c%0d got=%h want=%h", c, {mem_req, mem_we, mem_addr}, {1'b1, exp_d & d_write, e_addr}); end
                    if (exp_d && d_write) begin
                        n_cmp++; if (mem_wdata !== d_wdata) begin
                            n_fail++; $display("FAIL rnd_wdata c%0d got=%h want=%h", c, mem_wdata, d_wdata); end
                    end
                    m_busy = 1; m_own_d = exp_d;
                    if (exp_d && p_if) m_run = (m_run < MAX) ? m_run + 1 : m_run;
                    else m_run = 0;
                end else begin
                    n_cmp++; if (mem_req !== 1'b0) begin
                        n_fail++; $display("FAIL rnd_idle c%0d got=%b want=0", c, mem_req); end
                end
                n_cmp++; if ({if_ready, d_ready} !== 2'b00) begin
                    n_fail++; $display("FAIL rnd_no_ready c%0d got=%b want=00", c, {if_ready, d_ready}); end
            end else if (mem_ack) begin
                n_cmp++; if ({mem_req, if_ready, d_ready} !== {1'b0, ~m_own_d, m_own_d}) begin
                    n_fail++; $display("FAIL rnd_complete c%0d got=%b want=%b", c, {mem_req, if_ready, d_ready}, {1'b0, ~m_own_d, m_own_d}); end
                if (m_own_d) begin
                    if (!d_write) exp_d_rdata = rd(d_addr);
                    n_cmp++; if (d_rdata !== exp_d_rdata) begin
                        n_fail++; $display("FAIL rnd_d_rdata c%0d got=%h want=%h", c, d_rdata, exp_d_rdata); end
                    d_done = 1;
                end else begin
                    exp_if_rdata = rd(if_addr);
                    n_cmp++; if (if_rdata !== exp_if_rdata) begin
                        n_fail++; $display("FAIL rnd_if_rdata c%0d got=%h want=%h", c, if_rdata, exp_if_rdata); end
                    if_done = 1;
                end
                m_busy = 0;
            end else begin
                e_addr = m_own_d ? d_addr : if_addr;
                n_cmp++; if ({mem_req, if_ready, d_ready, mem_addr} !== {3'b100, e_addr}) begin
                    n_fail++; $display("FAIL rnd_hold c%0d got=%h want=%h", c, {mem_req, if_ready, d_ready, mem_addr}, {3'b100, e_addr}); end
            end
            if (if_done) start = ($urandom_range(0, 3) == 0);
            else start = !if_req && ($urandom_range(0, 2) == 0);
            if (if_done || start) if_req = start;
            if (start) if_addr = 32'($urandom_range(0, 255)) << 2;
            if (d_done) start = ($urandom_range(0, 1) == 0);
            else start = !(d_read | d_write) && ($urandom_range(0, 2) == 0);
            if (d_done && !start) begin
                d_read = 1'b0; d_write = 1'b0;
            end
            if (start) begin
                w = $urandom_range(0, 1) == 1;
                d_read = ~w; d_write = w;
                d_addr = 32'h1000 + (32'($urandom_range(0, 63)) << 2);
                d_wdata = $urandom;
            end
            p_if = if_req; p_d = d_read | d_write;
        end
    endtask

    initial begin
        RST = 1'b0;
        if_req = 1'b0; if_addr = '0;
        d_read = 1'b0; d_write = 1'b0; d_addr = '0; d_wdata = '0;
        test_reset();
        test_fetch_only();
        test_simultaneous();
        test_store();
        test_starvation();
        test_zero_wait();
        test_reset_mid();
        test_random(1500);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
